// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types and constants for the unified-memory port arbiter.
package memarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    // Size code used for every instruction fetch (full 32-bit word).
    localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/memarb_wdog.sv
// memarb_wdog: BUSY-cycle counter that flags a transaction stuck for TIMEOUT cycles.
module memarb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRE
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    // Count cycles spent waiting; cleared whenever a new transaction starts.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (CLR)
            cnt <= '0;
        else if (EN)
            cnt <= cnt + 16'd1;
    end

    // Fires during the TIMEOUT-th waiting cycle, so the abort edge ends exactly TIMEOUT cycles.
    assign EXPIRE = EN && (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and memory-access stages.
// Optional feature: define MEMARB_RR_EN for round-robin tie breaking (default: data wins ties).
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_ACK,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [2:0]        D_FUNC3,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ACK,
    output logic              M_REQ,
    output logic              M_WE,
    output logic [2:0]        M_FUNC3,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic [DATA_W-1:0] M_RDATA,
    input  logic              M_ACK,
    output logic              STALL_IF,
    output logic              STALL_MEM,
    output logic              ERR
);

    state_t state, state_nx;
    src_t   cur_src;    // owner of the in-flight / just-completed transaction
    src_t   win_src;
    src_t   tie_src;
    logic   elig_i, elig_d, grant;
    logic   done, abort, wd_expire;

`ifdef MEMARB_RR_EN
    src_t last_src;

    // Remember the most recent grant so the other side wins the next tie.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            last_src <= SRC_I;
        else if (grant)
            last_src <= win_src;
    end

    assign tie_src = (last_src == SRC_I) ? SRC_D : SRC_I;
`else
    // Data is the older instruction in the pipeline, so it wins ties.
    assign tie_src = SRC_D;
`endif

    // Eligibility, winner selection and next state; the side being acked sits out one cycle.
    always_comb begin
        state_nx = state;
        elig_i   = I_REQ && !(state == RESP && cur_src == SRC_I);
        elig_d   = D_REQ && !(state == RESP && cur_src == SRC_D);
        grant    = (state != BUSY) && (elig_i || elig_d);
        done     = (state == BUSY) && M_ACK;
        abort    = (state == BUSY) && !M_ACK && wd_expire;
        if (elig_i && elig_d)
            win_src = tie_src;
        else if (elig_d)
            win_src = SRC_D;
        else
            win_src = SRC_I;
        case (state)
            IDLE:    state_nx = grant ? BUSY : IDLE;
            BUSY:    state_nx = (done || abort) ? RESP : BUSY;
            RESP:    state_nx = grant ? BUSY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Transaction fields, read-data capture, completion pulses and sticky error.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cur_src <= SRC_I;
            M_REQ   <= 1'b0;
            M_WE    <= 1'b0;
            M_FUNC3 <= '0;
            M_ADDR  <= '0;
            M_WDATA <= '0;
            I_RDATA <= '0;
            D_RDATA <= '0;
            I_ACK   <= 1'b0;
            D_ACK   <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            I_ACK <= (done || abort) && (cur_src == SRC_I);
            D_ACK <= (done || abort) && (cur_src == SRC_D);
            if (grant) begin
                cur_src <= win_src;
                M_REQ   <= 1'b1;
                if (win_src == SRC_D) begin
                    M_WE    <= D_WE;
                    M_FUNC3 <= D_FUNC3;
                    M_ADDR  <= D_ADDR;
                    M_WDATA <= D_WDATA;
                end else begin
                    M_WE    <= 1'b0;
                    M_FUNC3 <= FUNC3_WORD;
                    M_ADDR  <= I_ADDR;
                end
            end else if (done || abort) begin
                M_REQ <= 1'b0;
                if (cur_src == SRC_I)
                    I_RDATA <= done ? M_RDATA : '0;
                else
                    D_RDATA <= done ? M_RDATA : '0;
            end
            if (abort)
                ERR <= 1'b1;
        end
    end

    memarb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLK    (CLK),
        .RESET  (RESET),
        .CLR    (grant),
        .EN     (state == BUSY),
        .EXPIRE (wd_expire)
    );

    assign STALL_IF  = I_REQ && !I_ACK;
    assign STALL_MEM = D_REQ && !D_ACK;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter, built with TIMEOUT=4.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_REQ, D_REQ, D_WE, M_ACK;
    logic [31:0] I_ADDR, D_ADDR, D_WDATA, M_RDATA;
    logic [2:0]  D_FUNC3;
    logic [31:0] I_RDATA, D_RDATA, M_ADDR, M_WDATA;
    logic        I_ACK, D_ACK, M_REQ, M_WE, STALL_IF, STALL_MEM, ERR;
    logic [2:0]  M_FUNC3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_FUNC3(D_FUNC3), .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA), .D_RDATA(D_RDATA), .D_ACK(D_ACK),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_FUNC3(M_FUNC3), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_ACK(M_ACK),
        .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM), .ERR(ERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; I_REQ = 0; D_REQ = 0; D_WE = 0; M_ACK = 0;
        I_ADDR = 0; D_ADDR = 0; D_WDATA = 0; M_RDATA = 0; D_FUNC3 = 0;
        tick(); tick();
        chk("rst_mreq", M_REQ, 0);
        chk("rst_acks", {I_ACK, D_ACK}, 0);
        chk("rst_err", ERR, 0);
        chk("rst_maddr", M_ADDR, 0);
        chk("rst_rdata", {I_RDATA, D_RDATA}, 0);
        RESET = 1'b0;
        tick();

        // lone fetch
        I_REQ = 1; I_ADDR = 32'h100;
        #1 chk("f_stall0", STALL_IF, 1);
        tick();
        chk("f_mreq", M_REQ, 1);
        chk("f_maddr", M_ADDR, 32'h100);
        chk("f_mwe_func3", {M_WE, M_FUNC3}, 4'b0010);
        chk("f_stall1", STALL_IF, 1);
        tick();
        chk("f_noack", I_ACK, 0);
        chk("f_stall2", STALL_IF, 1);
        M_ACK = 1; M_RDATA = 32'h00500093;
        tick();
        chk("f_iack", I_ACK, 1);
        chk("f_irdata", I_RDATA, 32'h00500093);
        chk("f_mreq_drop", M_REQ, 0);
        chk("f_stall3", STALL_IF, 0);
        M_ACK = 0; I_REQ = 0;
        tick();
        chk("f_iack_pulse", I_ACK, 0);

        // simultaneous fetch + load after a fresh reset: data first, then fetch with no gap
        RESET = 1; #1 RESET = 0;
        I_REQ = 1; I_ADDR = 32'h104;
        D_REQ = 1; D_WE = 0; D_ADDR = 32'h200; D_FUNC3 = 3'b010;
        tick();
        chk("t_maddr_d", M_ADDR, 32'h200);
        M_ACK = 1; M_RDATA = 32'h11111111;
        tick();
        chk("t_dack", D_ACK, 1);
        chk("t_drdata", D_RDATA, 32'h11111111);
        chk("t_stall_if", STALL_IF, 1);
        chk("t_stall_mem", STALL_MEM, 0);
        M_ACK = 0;
        tick();
        chk("t_mreq_i", M_REQ, 1);
        chk("t_maddr_i", M_ADDR, 32'h104);
        chk("t_dack_pulse", D_ACK, 0);
        chk("t_stall_if2", STALL_IF, 1);
        D_REQ = 0;
        M_ACK = 1; M_RDATA = 32'h22222222;
        tick();
        chk("t_iack", {I_ACK, D_ACK}, 2'b10);
        chk("t_irdata", I_RDATA, 32'h22222222);
        M_ACK = 0; I_REQ = 0;
        tick();
        chk("t_idle", {M_REQ, I_ACK}, 0);

        // store
        D_REQ = 1; D_WE = 1; D_ADDR = 32'h204; D_WDATA = 32'hDEADBEEF; D_FUNC3 = 3'b000;
        tick();
        chk("s_mreq", M_REQ, 1);
        chk("s_fields", {M_WE, M_FUNC3, M_ADDR, M_WDATA}, {1'b1, 3'b000, 32'h204, 32'hDEADBEEF});
        tick();
        chk("s_hold", {M_REQ, M_ADDR}, {1'b1, 32'h204});
        M_ACK = 1; M_RDATA = 32'h33;
        tick();
        chk("s_dack", D_ACK, 1);
        D_REQ = 0; D_WE = 0; M_ACK = 0;
        tick();
        chk("s_dack_pulse", D_ACK, 0);

        // watchdog abort after 4 BUSY cycles
        I_REQ = 1; I_ADDR = 32'h300;
        tick();
        chk("w_b1", M_REQ, 1);
        tick();
        chk("w_b2", M_REQ, 1);
        tick();
        chk("w_b3", M_REQ, 1);
        tick();
        chk("w_b4", {M_REQ, ERR}, 2'b10);
        tick();
        chk("w_abort", {M_REQ, I_ACK, ERR}, 3'b011);
        chk("w_rdata0", I_RDATA, 0);
        I_REQ = 0;
        tick();
        chk("w_err_sticky", {I_ACK, ERR}, 2'b01);
        D_REQ = 1; D_ADDR = 32'h208;
        tick();
        chk("w_next_mreq", M_REQ, 1);
        M_ACK = 1; M_RDATA = 32'h44;
        tick();
        chk("w_next_dack", {D_ACK, D_RDATA}, {1'b1, 32'h44});
        chk("w_err_still", ERR, 1);
        D_REQ = 0; M_ACK = 0;
        tick();

        // reset mid-BUSY
        I_REQ = 1; I_ADDR = 32'h400;
        tick();
        chk("r_busy", M_REQ, 1);
        #2 RESET = 1; I_REQ = 0;
        #1;
        chk("r_async", {M_REQ, I_ACK, D_ACK, ERR}, 0);
        chk("r_async_addr", M_ADDR, 0);
        tick();
        RESET = 0;
        tick();
        M_ACK = 1; M_RDATA = 32'h55;
        tick();
        M_ACK = 0;
        chk("r_stray_ack", {I_ACK, D_ACK, M_REQ}, 0);
        tick();
        chk("r_stray_ack2", {I_ACK, D_ACK}, 0);

        // both held: grants alternate D,I,D,I,D,I
        RESET = 1; #1 RESET = 0;
        I_REQ = 1; I_ADDR = 32'h500; D_REQ = 1; D_WE = 0; D_ADDR = 32'h600;
        tick();
        for (int n = 0; n < 6; n++) begin
            chk("a_maddr", M_ADDR, (n % 2) ? 32'h500 : 32'h600);
            M_ACK = 1; M_RDATA = 32'h10 + n;
            tick();
            chk("a_ack", {I_ACK, D_ACK}, (n % 2) ? 2'b10 : 2'b01);
            M_ACK = 0;
            if (n == 5) begin
                I_REQ = 0; D_REQ = 0;
            end
            tick();
        end
        chk("a_idle", M_REQ, 0);

        // tie right after a data grant
        D_REQ = 1; D_ADDR = 32'h700;
        tick();
        chk("p_maddr", M_ADDR, 32'h700);
        M_ACK = 1;
        tick();
        chk("p_dack", D_ACK, 1);
        D_REQ = 0; M_ACK = 0;
        tick();
        I_REQ = 1; I_ADDR = 32'h704; D_REQ = 1; D_ADDR = 32'h708;
        tick();
`ifdef MEMARB_RR_EN
        chk("p_tie_rr", M_ADDR, 32'h704);
`else
        chk("p_tie_fixed", M_ADDR, 32'h708);
`endif
        M_ACK = 1;
        tick();
        M_ACK = 0; I_REQ = 0; D_REQ = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
